// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the fetch sequencer: state encoding, PC-select constants
// and the redirect decode.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        StBoot   = 3'd0,
        StFetch  = 3'd1,
        StExec   = 3'd2,
        StHalted = 3'd3,
        StFault  = 3'd4
    } state_e;

    localparam logic SEL_INC = 1'b0;
    localparam logic SEL_TGT = 1'b1;

    localparam int unsigned TimerWidth = 8;

    function automatic logic redirect(input logic branch, input logic zero, input logic jmp,
                                      input logic jr, input logic jal);
        return (branch & zero) | jmp | jr | jal;
    endfunction

endpackage

// File: rtl/ack_timer.sv
// Counts FETCH wait cycles; expired_o flags the last allowed cycle of the ack window.
module ack_timer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned Limit = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam logic [TimerWidth-1:0] LastCnt = TimerWidth'(Limit - 1);

    logic [TimerWidth-1:0] cnt_q;
    logic [TimerWidth-1:0] cnt_d;

    assign expired_o = (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch/execute sequencer with ack timeout, halt/resume and a
// retired-instruction counter.
module fetch_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_ack,
    input  logic        halt,
    input  logic        resume,
    input  logic        branch,
    input  logic        zero,
    input  logic        jmp,
    input  logic        jr,
    input  logic        jal,
    output logic        imem_req,
    output logic        ir_load,
    output logic        pc_write,
    output logic        pc_sel,
    output logic        commit,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instr_count
);

    state_e      state_q;
    state_e      state_d;
    logic [31:0] instr_count_q;
    logic        count_inc;
    logic        timer_expired;

    ack_timer #(
        .Limit(ACK_TIMEOUT)
    ) u_ack_timer (
        .clk_i      (clock),
        .rst_i      (reset),
        .clear_i    (state_q != StFetch),
        .count_en_i (state_q == StFetch && !imem_ack),
        .expired_o  (timer_expired)
    );

    // Outputs depend only on registered state plus the inputs each state consumes, so halt
    // never reaches imem_req combinationally.
    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = SEL_INC;
        commit    = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        count_inc = 1'b0;
        unique case (state_q)
            StBoot: state_d = StFetch;
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_d = StExec;
                end else if (timer_expired) begin
                    state_d = StFault;
                end
            end
            StExec: begin
                if (halt) begin
                    state_d = StHalted;
                end else begin
                    pc_write  = 1'b1;
                    commit    = 1'b1;
                    count_inc = 1'b1;
                    pc_sel    = redirect(branch, zero, jmp, jr, jal) ? SEL_TGT : SEL_INC;
                    state_d   = StFetch;
                end
            end
            StHalted: begin
                halted = 1'b1;
                if (resume) state_d = StFetch;
            end
            StFault: fault = 1'b1;
            default: state_d = StBoot;
        endcase
        if (reset) begin
            imem_req  = 1'b0;
            ir_load   = 1'b0;
            pc_write  = 1'b0;
            pc_sel    = SEL_INC;
            commit    = 1'b0;
            halted    = 1'b0;
            fault     = 1'b0;
            count_inc = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StBoot;
            instr_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (count_inc) instr_count_q <= instr_count_q + 32'd1;
        end
    end

    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer built with ACK_TIMEOUT = 4.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_ack, halt, resume, branch, zero, jmp, jr, jal;
    logic        imem_req, ir_load, pc_write, pc_sel, commit, halted, fault;
    logic [31:0] instr_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_count = 32'd0;

    // Output vector order: {imem_req, ir_load, pc_write, pc_sel, commit, halted, fault}
    localparam logic [6:0] OutIdle  = 7'b000_0000;
    localparam logic [6:0] OutFetch = 7'b100_0000;
    localparam logic [6:0] OutLoad  = 7'b110_0000;
    localparam logic [6:0] OutInc   = 7'b001_0100;
    localparam logic [6:0] OutTgt   = 7'b001_1100;
    localparam logic [6:0] OutHalt  = 7'b000_0010;
    localparam logic [6:0] OutFault = 7'b000_0001;

    fetch_sequencer #(
        .ACK_TIMEOUT(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_ack    (imem_ack),
        .halt        (halt),
        .resume      (resume),
        .branch      (branch),
        .zero        (zero),
        .jmp         (jmp),
        .jr          (jr),
        .jal         (jal),
        .imem_req    (imem_req),
        .ir_load     (ir_load),
        .pc_write    (pc_write),
        .pc_sel      (pc_sel),
        .commit      (commit),
        .halted      (halted),
        .fault       (fault),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [6:0] exp);
        check_eq(tag, {25'd0, imem_req, ir_load, pc_write, pc_sel, commit, halted, fault},
                 {25'd0, exp});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack = 1'b0; halt = 1'b0; resume = 1'b0;
        branch = 1'b0; zero = 1'b0; jmp = 1'b0; jr = 1'b0; jal = 1'b0;
    endtask

    // Entered in a FETCH cycle: ack immediately, then one EXEC with the given jump class.
    task automatic fetch_exec(input string tag, input logic [4:0] cls, input logic [6:0] exp);
        imem_ack = 1'b1;
        #1;
        check_outs({tag, "_fetch"}, OutLoad);
        tick();
        imem_ack = 1'b0;
        {branch, zero, jmp, jr, jal} = cls;
        #1;
        check_outs({tag, "_exec"}, exp);
        tick();
        clear_inputs();
        exp_count = exp_count + 32'd1;
        #1;
        check_eq({tag, "_count"}, instr_count, exp_count);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        check_outs("reset_outs", OutIdle);
        check_eq("reset_count", instr_count, 32'd0);

        // Ack on the second FETCH cycle, plain instruction
        reset = 1'b0;
        #1;
        check_outs("boot_outs", OutIdle);
        tick();
        check_outs("fetch1_no_ack", OutFetch);
        tick();
        imem_ack = 1'b1;
        #1;
        check_outs("fetch2_ack_load", OutLoad);
        tick();
        imem_ack = 1'b0;
        #1;
        check_outs("exec_plain", OutInc);
        tick();
        exp_count = 32'd1;
        check_eq("count_after_first", instr_count, exp_count);
        check_outs("refetch", OutFetch);

        // Redirect decode: {branch, zero, jmp, jr, jal}
        fetch_exec("br_taken",   5'b11000, OutTgt);
        fetch_exec("br_untaken", 5'b10000, OutInc);
        fetch_exec("zero_only",  5'b01000, OutInc);
        fetch_exec("jal",        5'b00001, OutTgt);
        fetch_exec("jmp",        5'b00100, OutTgt);
        fetch_exec("jr",         5'b00010, OutTgt);

        // Halt overrides a simultaneous jump
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        halt = 1'b1;
        jmp = 1'b1;
        #1;
        check_eq("halt_pc_write", {31'd0, pc_write}, 32'd0);
        check_eq("halt_commit", {31'd0, commit}, 32'd0);
        tick();
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            imem_ack = i[0];
            branch = 1'b1;
            halt = 1'b1;
            #1;
            check_outs("halted_hold", OutHalt);
            tick();
        end
        clear_inputs();
        resume = 1'b1;
        #1;
        check_outs("halted_resume_cycle", OutHalt);
        tick();
        resume = 1'b0;
        #1;
        check_outs("resume_refetch", OutFetch);
        check_eq("halt_count_unchanged", instr_count, exp_count);

        // Counter wrap
        force dut.instr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count_q;
        #1;
        check_eq("count_preset", instr_count, 32'hFFFF_FFFF);
        exp_count = 32'hFFFF_FFFF;
        fetch_exec("wrap", 5'b00000, OutInc);

        // Reset in the middle of FETCH
        check_outs("pre_reset_fetch", OutFetch);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_outs("mid_fetch_reset_boot", OutIdle);
        check_eq("mid_fetch_reset_count", instr_count, 32'd0);
        exp_count = 32'd0;
        tick();

        // No ack: four FETCH cycles, then FAULT sticks until reset
        for (int i = 0; i < 4; i++) begin
            #1;
            check_outs("timeout_wait", OutFetch);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            imem_ack = i[0];
            resume = i[1];
            halt = i[2];
            #1;
            check_outs("fault_sticky", OutFault);
            tick();
        end
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_outs("fault_reset_boot", OutIdle);
        tick();

        // Ack in the last allowed FETCH cycle is accepted
        for (int i = 0; i < 3; i++) begin
            #1;
            check_outs("late_ack_wait", OutFetch);
            tick();
        end
        imem_ack = 1'b1;
        #1;
        check_outs("late_ack_load", OutLoad);
        tick();
        imem_ack = 1'b0;
        #1;
        check_outs("late_ack_exec", OutInc);
        tick();
        exp_count = exp_count + 32'd1;
        check_outs("late_ack_refetch", OutFetch);
        check_eq("late_ack_count", instr_count, exp_count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16: maximum FETCH cycles waited for imem_ack before faulting (legal range 1..255).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port imem_ack  input  1  instruction memory has valid data this cycle.
REQ-005 SHALL have port halt  input  1  decoded halt for the instruction in EXEC.
REQ-006 SHALL have port resume  input  1  leave HALTED.
REQ-007 SHALL have port branch  input  1  branch instruction in EXEC (PCSrc).
REQ-008 SHALL have port zero  input  1  ALU zero flag.
REQ-009 SHALL have ports jmp, jr, jal  input  1 each  jump class of the instruction in EXEC.
REQ-010 SHALL have port imem_req  output  1  fetch request.
REQ-011 SHALL have port ir_load  output  1  latch instruction register.
REQ-012 SHALL have port pc_write  output  1  PC register update enable.
REQ-013 SHALL have port pc_sel  output  1  0 = PC+1, 1 = redirect target.
REQ-014 SHALL have port commit  output  1  instruction retires this cycle (gates register-file/memory writes).
REQ-015 SHALL have ports halted, fault  output  1 each  status flags.
REQ-016 SHALL have port instr_count  output  32  retired-instruction counter.

Function
REQ-017 SHALL implement states BOOT, FETCH, EXEC, HALTED, FAULT.
REQ-018 BOOT SHALL last exactly one cycle after reset deasserts, drive all outputs 0, then go to FETCH.
REQ-019 FETCH SHALL assert imem_req; on imem_ack, ir_load=1 in the same cycle and next state EXEC.
REQ-020 FETCH SHALL count wait cycles; if ACK_TIMEOUT cycles pass without imem_ack, next state FAULT; an ack in the final allowed cycle SHALL be accepted.
REQ-021 EXEC SHALL last exactly one cycle; fetch-to-commit latency is therefore ack cycle + 1.
REQ-022 In EXEC with halt=0: pc_write=1, commit=1, instr_count increments, next state FETCH.
REQ-023 In EXEC, pc_sel SHALL be 1 iff (branch AND zero) OR jmp OR jr OR jal; else 0.
REQ-024 In EXEC with halt=1: pc_write=0, commit=0, no count, next state HALTED; halt SHALL override any simultaneous branch/jump.
REQ-025 HALTED SHALL assert halted, hold all other outputs 0, and go to FETCH on the cycle resume=1.
REQ-026 FAULT SHALL assert fault, hold all other outputs 0, and be left only by reset.
REQ-027 imem_ack, halt, resume and branch/jump inputs SHALL be ignored outside the states that consume them.
REQ-028 instr_count SHALL wrap from 0xFFFFFFFF to 0 without flag.
REQ-029 pc_write, commit and ir_load SHALL never be asserted in the same cycle as each other except pc_write with commit.

Reset
REQ-030 Reset SHALL take priority over every other input in any state, including mid-FETCH and FAULT.
REQ-031 On reset: state BOOT, timeout counter 0, instr_count 0, all outputs 0.

Structure
REQ-032 State encoding and pc_sel constants (SEL_INC=0, SEL_TGT=1) SHALL live in shared package cpu_ctrl_pkg.
REQ-033 The timeout counter SHALL be sub-module ack_timer (load/clear, count enable, expired output).
REQ-034 Outputs SHALL be decoded from registered state plus inputs; no combinational path from halt to imem_req.

Verification
REQ-035 Reset then imem_ack on 2nd FETCH cycle, plain instruction -> ir_load at cycle 3, pc_write=1 pc_sel=0 commit=1 at cycle 4, instr_count=1.
REQ-036 EXEC with branch=1, zero=1 -> pc_sel=1; branch=1, zero=0 -> pc_sel=0; jal=1 -> pc_sel=1.
REQ-037 EXEC with halt=1 and jmp=1 -> pc_write=0, halted=1 next cycle; resume after 5 cycles -> imem_req=1 next cycle, count unchanged.
REQ-038 ACK_TIMEOUT=4, no ack -> fault=1 after 4 FETCH cycles, persists 20 cycles; ack at 4th cycle instead -> EXEC, no fault.
REQ-039 Force instr_count=0xFFFFFFFF, retire one -> 0; assert reset mid-FETCH -> BOOT next cycle, all outputs 0.
